// File: rtl/sd_pkg.sv
// Shared types, constants and address helper for the SD stream write path.
package sd_pkg;

  localparam int unsigned SD_SECTOR_BYTES = 512;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StResp,
    StFinish
  } sd_wr_state_t;

  typedef enum logic [1:0] {
    SdErrNone    = 2'd0,
    SdErrBresp   = 2'd1,
    SdErrTimeout = 2'd2
  } sd_err_t;

  // Byte address of one word; wraps modulo 2^32 like the sector arithmetic upstream.
  function automatic logic [31:0] sd_word_addr(logic [31:0] sector, logic [15:0] sec_idx,
                                                logic [6:0] word_idx);
    logic [31:0] sec_abs;
    sec_abs = sector + 32'(sec_idx);
    return (sec_abs * SD_SECTOR_BYTES) + {23'd0, word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/sd_axil_wr_beat.sv
// One AXI-Lite write beat: AW+W issue followed by the B response.
// Optional watchdog on the beat enabled by SD_STREAM_WRITER_TIMEOUT_EN.
module sd_axil_wr_beat
  import sd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        complete,
  output logic [1:0]  resp,
  output logic        timeout,
  output logic [31:0] m_axil_awaddr,
  output logic        m_axil_awvalid,
  input  logic        m_axil_awready,
  output logic [31:0] m_axil_wdata,
  output logic        m_axil_wvalid,
  input  logic        m_axil_wready,
  input  logic [1:0]  m_axil_bresp,
  input  logic        m_axil_bvalid,
  output logic        m_axil_bready
);

  logic issuing_q;
  logic issue_done;

  // Both channels finished, whichever order the slave accepted them in.
  assign issue_done = (!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready);
  assign complete   = m_axil_bready && m_axil_bvalid;
  assign resp       = m_axil_bresp;

`ifdef SD_STREAM_WRITER_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TimerW-1:0] timer_q;
  logic              waiting;
  logic              progress;

  assign waiting  = issuing_q || m_axil_bready;
  assign progress = issuing_q ? issue_done : m_axil_bvalid;
  assign timeout  = waiting && !progress && (timer_q == TimerW'(TIMEOUT_CYCLES - 1));

  // Restarts on entry to the issue phase and again on entry to the response phase.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      timer_q <= '0;
    end else if (start || !waiting || progress) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      issuing_q      <= 1'b0;
      m_axil_awaddr  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
    end else if (timeout) begin
      issuing_q      <= 1'b0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
    end else if (start) begin
      issuing_q      <= 1'b1;
      m_axil_awaddr  <= addr;
      m_axil_awvalid <= 1'b1;
      m_axil_wdata   <= data;
      m_axil_wvalid  <= 1'b1;
    end else if (issuing_q) begin
      if (m_axil_awready) begin
        m_axil_awvalid <= 1'b0;
      end
      if (m_axil_wready) begin
        m_axil_wvalid <= 1'b0;
      end
      if (issue_done) begin
        issuing_q     <= 1'b0;
        m_axil_bready <= 1'b1;
      end
    end else if (complete) begin
      m_axil_bready <= 1'b0;
    end
  end

endmodule

// File: rtl/sd_stream_writer.sv
// Turns a (sector, count) write command plus a word stream into AXI-Lite single-beat writes.
// Define SD_STREAM_WRITER_TIMEOUT_EN to enable the per-beat response watchdog.
module sd_stream_writer
  import sd_pkg::*;
#(
  parameter int unsigned SECTOR_WORDS   = 128,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_sector,
  input  logic [15:0] cmd_count,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [31:0] s_tdata,
  output logic [31:0] m_axil_awaddr,
  output logic [2:0]  m_axil_awprot,
  output logic        m_axil_awvalid,
  input  logic        m_axil_awready,
  output logic [31:0] m_axil_wdata,
  output logic [3:0]  m_axil_wstrb,
  output logic        m_axil_wvalid,
  input  logic        m_axil_wready,
  input  logic [1:0]  m_axil_bresp,
  input  logic        m_axil_bvalid,
  output logic        m_axil_bready,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [31:0] words_written
);

  localparam logic [6:0] LastWord = 7'(SECTOR_WORDS - 1);

  sd_wr_state_t state_q;
  logic [31:0]  sector_q;
  logic [15:0]  count_q;
  logic [6:0]   word_idx_q;
  logic [15:0]  sec_idx_q;
  logic         cmd_ready_q;
  logic         s_tready_q;
  logic         busy_q;
  logic         done_q;
  sd_err_t      err_q;
  logic [31:0]  words_q;

  logic         beat_start;
  logic         beat_complete;
  logic         beat_timeout;
  logic [1:0]   beat_resp;
  logic [31:0]  beat_addr;
  logic         issue_done;

  assign beat_start = (state_q == StFetch) && s_tready_q && s_tvalid;
  assign beat_addr  = sd_word_addr(sector_q, sec_idx_q, word_idx_q);
  assign issue_done = (!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready);

  assign cmd_ready     = cmd_ready_q;
  assign s_tready      = s_tready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_code      = err_q;
  assign words_written = words_q;
  assign m_axil_awprot = 3'b000;
  assign m_axil_wstrb  = 4'hF;

  sd_axil_wr_beat #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_beat (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (beat_start),
    .addr          (beat_addr),
    .data          (s_tdata),
    .complete      (beat_complete),
    .resp          (beat_resp),
    .timeout       (beat_timeout),
    .m_axil_awaddr (m_axil_awaddr),
    .m_axil_awvalid(m_axil_awvalid),
    .m_axil_awready(m_axil_awready),
    .m_axil_wdata  (m_axil_wdata),
    .m_axil_wvalid (m_axil_wvalid),
    .m_axil_wready (m_axil_wready),
    .m_axil_bresp  (m_axil_bresp),
    .m_axil_bvalid (m_axil_bvalid),
    .m_axil_bready (m_axil_bready)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      sector_q    <= '0;
      count_q     <= '0;
      word_idx_q  <= '0;
      sec_idx_q   <= '0;
      cmd_ready_q <= 1'b1;
      s_tready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= SdErrNone;
      words_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            sector_q    <= cmd_sector;
            count_q     <= cmd_count;
            word_idx_q  <= '0;
            sec_idx_q   <= '0;
            err_q       <= SdErrNone;
            words_q     <= '0;
            cmd_ready_q <= 1'b0;
            if (cmd_count == 16'd0) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end else begin
              busy_q     <= 1'b1;
              s_tready_q <= 1'b1;
              state_q    <= StFetch;
            end
          end
        end
        StFetch: begin
          if (s_tvalid) begin
            s_tready_q <= 1'b0;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (beat_timeout) begin
            err_q   <= SdErrTimeout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StFinish;
          end else if (issue_done) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          if (beat_complete) begin
            if (beat_resp != AXI_RESP_OKAY) begin
              // Leftover stream words stay unconsumed; the source flushes them.
              err_q   <= SdErrBresp;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StFinish;
            end else begin
              words_q <= words_q + 32'd1;
              if (word_idx_q == LastWord) begin
                word_idx_q <= '0;
                sec_idx_q  <= sec_idx_q + 16'd1;
                if (sec_idx_q == count_q - 16'd1) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StFinish;
                end else begin
                  s_tready_q <= 1'b1;
                  state_q    <= StFetch;
                end
              end else begin
                word_idx_q <= word_idx_q + 7'd1;
                s_tready_q <= 1'b1;
                state_q    <= StFetch;
              end
            end
          end else if (beat_timeout) begin
            err_q   <= SdErrTimeout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StFinish;
          end
        end
        StFinish: begin
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
